// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between EXU (A) and LSU (B) writebacks.
// It also keeps a per-register pending scoreboard for RAW/WAW hazard reporting.
module regfile_wb_arbiter #(
    parameter int unsigned NREG   = 16,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              raw_hazard,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [NREG-1:0]   pending,
    output logic              wb_err
);

    localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    logic              ptr_b;
    logic              a_grant;
    logic              b_grant;
    logic              xfer;
    logic [ADDR_W-1:0] x_rd;
    logic [DATA_W-1:0] x_data;
    logic              err_set;
    logic [NREG-1:0]   pending_nxt;

    function automatic logic in_range(input logic [ADDR_W-1:0] r);
        return 32'(r) < NREG;
    endfunction

    // x0 and reserved indices are never considered pending
    function automatic logic is_pend(input logic [NREG-1:0] p, input logic [ADDR_W-1:0] r);
        return (r != '0) && in_range(r) && p[r[IDX_W-1:0]];
    endfunction

    // Round-robin grant: ptr_b set means B wins a tie
    always_comb begin
        a_grant = a_valid && (!b_valid || !ptr_b);
        b_grant = b_valid && (!a_valid || ptr_b);
        xfer    = a_grant || b_grant;
        x_rd    = b_grant ? b_rd : a_rd;
        x_data  = b_grant ? b_data : a_data;
    end

    assign a_ready     = a_grant;
    assign b_ready     = b_grant;
    assign issue_ready = !is_pend(pending, issue_rd);
    assign raw_hazard  = is_pend(pending, rs1) || is_pend(pending, rs2);

    // Clear on commit first so a same-cycle issue of that index wins
    always_comb begin
        pending_nxt = pending;
        if (rf_wen && in_range(rf_rd)) begin
            pending_nxt[rf_rd[IDX_W-1:0]] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != '0) && in_range(issue_rd)) begin
            pending_nxt[issue_rd[IDX_W-1:0]] = 1'b1;
        end
        err_set = (xfer && (x_rd != '0) && !is_pend(pending, x_rd))
               || (issue_valid && !in_range(issue_rd));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            pending  <= '0;
            wb_err   <= 1'b0;
            ptr_b    <= 1'b0;
        end else begin
            rf_wen  <= xfer && (x_rd != '0);
            pending <= pending_nxt;
            wb_err  <= wb_err || err_set;
            if (xfer) begin
                rf_rd    <= x_rd;
                rf_wdata <= x_data;
            end
            if (a_grant) begin
                ptr_b <= 1'b1;
            end else if (b_grant) begin
                ptr_b <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then random traffic, all checked against a cycle model kept in the bench.
module tb_regfile_wb_arbiter;

    localparam int NREG   = 16;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              issue_ready;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              raw_hazard;
    logic              a_valid;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              rf_wen;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wdata;
    logic [NREG-1:0]   pending;
    logic              wb_err;

    regfile_wb_arbiter #(.NREG(NREG), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .raw_hazard(raw_hazard),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .pending(pending), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    bit              pend [NREG];
    bit              fav_b;
    bit              m_err;
    bit              m_wen;
    logic [ADDR_W-1:0] m_rd;
    logic [DATA_W-1:0] m_data;
    bit              ga;
    bit              gb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit valid_idx(input logic [ADDR_W-1:0] r);
        return int'(r) < NREG;
    endfunction

    function automatic bit busy(input logic [ADDR_W-1:0] r);
        if (r == 0 || !valid_idx(r)) return 1'b0;
        return pend[r[3:0]];
    endfunction

    function automatic logic [31:0] pend_vec();
        logic [31:0] v = 0;
        for (int i = 0; i < NREG; i++) v[i] = pend[i];
        return v;
    endfunction

    // Compare every DUT output against the model, after inputs have settled
    task automatic check_now();
        #1;
        if (a_valid && b_valid) begin
            ga = !fav_b;
            gb = fav_b;
        end else begin
            ga = a_valid;
            gb = b_valid;
        end
        chk("issue_ready", 32'(issue_ready), 32'(!busy(issue_rd)));
        chk("raw_hazard", 32'(raw_hazard), 32'(busy(rs1) || busy(rs2)));
        chk("a_ready", 32'(a_ready), 32'(ga));
        chk("b_ready", 32'(b_ready), 32'(gb));
        chk("rf_wen", 32'(rf_wen), 32'(m_wen));
        if (m_wen) begin
            chk("rf_rd", 32'(rf_rd), 32'(m_rd));
            chk("rf_wdata", rf_wdata, m_data);
        end
        chk("pending", 32'(pending), pend_vec());
        chk("wb_err", 32'(wb_err), 32'(m_err));
    endtask

    // Advance the model and DUT by one clock using the current inputs
    task automatic tick();
        bit                npend [NREG];
        bit                nerr;
        bit                x;
        logic [ADDR_W-1:0] xrd;
        logic [DATA_W-1:0] xdata;
        npend = pend;
        if (m_wen && valid_idx(m_rd)) npend[m_rd[3:0]] = 1'b0;
        if (issue_valid && !busy(issue_rd) && issue_rd != 0 && valid_idx(issue_rd))
            npend[issue_rd[3:0]] = 1'b1;
        x     = ga || gb;
        xrd   = gb ? b_rd : a_rd;
        xdata = gb ? b_data : a_data;
        nerr  = m_err || (x && xrd != 0 && !busy(xrd)) || (issue_valid && !valid_idx(issue_rd));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
            fav_b  = 1'b0;
            m_err  = 1'b0;
            m_wen  = 1'b0;
            m_rd   = '0;
            m_data = '0;
        end else begin
            pend  = npend;
            m_err = nerr;
            m_wen = x && xrd != 0;
            if (x) begin
                m_rd   = xrd;
                m_data = xdata;
            end
            if (ga) fav_b = 1'b1;
            else if (gb) fav_b = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
        a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;
    endtask

    task automatic issue(input int r);
        idle();
        issue_valid = 1; issue_rd = ADDR_W'(r);
        check_now(); tick();
    endtask

    function automatic logic [ADDR_W-1:0] pick_rd();
        int cand[$];
        int r = int'($urandom_range(0, 9));
        for (int i = 1; i < NREG; i++) if (pend[i]) cand.push_back(i);
        if (r < 7 && cand.size() > 0) return ADDR_W'(cand[$urandom_range(0, cand.size() - 1)]);
        if (r == 7) return '0;
        if (r == 8) return ADDR_W'($urandom_range(16, 31));
        return ADDR_W'($urandom_range(1, 15));
    endfunction

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        check_now(); tick();
        idle();
        check_now();
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_rf_wen", 32'(rf_wen), 32'h0);
        chk("reset_rf_rd", 32'(rf_rd), 32'h0);
        chk("reset_rf_wdata", rf_wdata, 32'h0);
        chk("reset_wb_err", 32'(wb_err), 32'h0);
        tick();

        // Issue x5, RAW on x5, A writes x5, hazard drops after commit
        issue(5);
        rs1 = 5; issue_valid = 0;
        check_now();
        chk("t1_pending5", 32'(pending[5]), 32'h1);
        chk("t1_raw", 32'(raw_hazard), 32'h1);
        tick();
        rs1 = 5; a_valid = 1; a_rd = 5; a_data = 32'h1234;
        check_now();
        chk("t1_a_ready", 32'(a_ready), 32'h1);
        tick();
        a_valid = 0;
        check_now();
        chk("t1_rf_wen", 32'(rf_wen), 32'h1);
        chk("t1_rf_rd", 32'(rf_rd), 32'h5);
        chk("t1_rf_wdata", rf_wdata, 32'h1234);
        chk("t1_raw_still", 32'(raw_hazard), 32'h1);
        tick();
        check_now();
        chk("t1_pending5_clr", 32'(pending[5]), 32'h0);
        chk("t1_raw_clr", 32'(raw_hazard), 32'h0);
        tick();

        // WAW stall on x7 until its write commits
        issue(7);
        issue_valid = 1; issue_rd = 7;
        check_now();
        chk("t3_stall", 32'(issue_ready), 32'h0);
        tick();
        a_valid = 1; a_rd = 7; a_data = 32'h77;
        check_now();
        chk("t3_stall2", 32'(issue_ready), 32'h0);
        tick();
        a_valid = 0;
        check_now();
        chk("t3_commit_stall", 32'(issue_ready), 32'h0);
        tick();
        check_now();
        chk("t3_release", 32'(issue_ready), 32'h1);
        tick();
        idle();
        a_valid = 1; a_rd = 7; a_data = 32'h78;
        check_now(); tick();
        idle(); check_now(); tick();

        // Write to x0 is consumed without effect
        a_valid = 1; a_rd = 0; a_data = 32'hFFFF_FFFF;
        check_now();
        chk("t4_a_ready", 32'(a_ready), 32'h1);
        tick();
        idle();
        check_now();
        chk("t4_rf_wen", 32'(rf_wen), 32'h0);
        chk("t4_pending", 32'(pending), 32'h0);
        chk("t4_wb_err", 32'(wb_err), 32'h0);
        tick();

        // Stray writeback to x9 sets sticky error but still writes
        b_valid = 1; b_rd = 9; b_data = 32'h99;
        check_now();
        chk("t5_b_ready", 32'(b_ready), 32'h1);
        tick();
        idle();
        check_now();
        chk("t5_rf_wen", 32'(rf_wen), 32'h1);
        chk("t5_wb_err", 32'(wb_err), 32'h1);
        tick(); tick();
        check_now();
        chk("t5_wb_err_sticky", 32'(wb_err), 32'h1);
        tick();

        // Simultaneous A(x3)/B(x4): A first, then B, back-to-back commits
        issue(3);
        issue(4);
        idle();
        a_valid = 1; a_rd = 3; a_data = 32'h33;
        b_valid = 1; b_rd = 4; b_data = 32'h44;
        check_now();
        chk("t2_a_first", 32'(a_ready), 32'h1);
        chk("t2_b_wait", 32'(b_ready), 32'h0);
        tick();
        a_valid = 0;
        check_now();
        chk("t2_b_second", 32'(b_ready), 32'h1);
        chk("t2_wen1_rd", 32'(rf_rd), 32'h3);
        tick();
        b_valid = 0;
        check_now();
        chk("t2_wen2", 32'(rf_wen), 32'h1);
        chk("t2_wen2_rd", 32'(rf_rd), 32'h4);
        tick();

        // Reset with a transfer in flight and pending bits set
        issue(2);
        issue(6);
        idle();
        rst = 1; a_valid = 1; a_rd = 2; a_data = 32'h22;
        check_now(); tick();
        idle();
        a_valid = 1; a_rd = 0; b_valid = 1; b_rd = 0;
        check_now();
        chk("t6_rf_wen", 32'(rf_wen), 32'h0);
        chk("t6_pending", 32'(pending), 32'h0);
        chk("t6_wb_err", 32'(wb_err), 32'h0);
        chk("t6_a_wins", 32'(a_ready), 32'h1);
        tick();
        idle(); check_now(); tick();

        // Random traffic obeying hold-until-ready
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (a_valid && ga) a_valid = 0;
            if (b_valid && gb) b_valid = 0;
            if (!a_valid && $urandom_range(0, 9) < 4) begin
                a_valid = 1; a_rd = pick_rd(); a_data = $urandom;
            end
            if (!b_valid && $urandom_range(0, 9) < 4) begin
                b_valid = 1; b_rd = pick_rd(); b_data = $urandom;
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = ($urandom_range(0, 19) == 0) ? ADDR_W'($urandom_range(0, 31))
                                                    : ADDR_W'($urandom_range(1, 15));
            rs1 = ADDR_W'($urandom_range(0, 15));
            rs2 = ADDR_W'($urandom_range(0, 15));
            check_now();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Owns the single write port of the RV32E register file and shares it between two writeback sources: A is the EXU/ALU result and B is the LSU load result.
Arbitrates with a valid/ready handshake and round-robin priority, then drives registered wen/rd/data to the register file.
Keeps a per-register pending scoreboard, set at issue and cleared at write commit, and reports RAW/WAW hazards to the decode/issue stage.

Parameters:
NREG, 16, number of architectural registers tracked (RV32E); must be a power of two ≤ 32.
ADDR_W, 5, register index width, matching rs1/rs2/rd of the register file.
DATA_W, 32, register data width.

Ports:
clk  input  1  clock
rst  input  1  reset
issue_valid  input  1  decode is issuing an instruction that writes issue_rd
issue_rd  input  ADDR_W  destination register of the issuing instruction
issue_ready  output  1  issue accepted this cycle (no WAW on issue_rd)
rs1  input  ADDR_W  source index 1 of the instruction in decode
rs2  input  ADDR_W  source index 2 of the instruction in decode
raw_hazard  output  1  rs1 or rs2 has a pending write
a_valid  input  1  EXU writeback request
a_rd  input  ADDR_W  EXU destination register
a_data  input  DATA_W  EXU result
a_ready  output  1  EXU request granted
b_valid  input  1  LSU writeback request
b_rd  input  ADDR_W  LSU destination register
b_data  input  DATA_W  LSU load data
b_ready  output  1  LSU request granted
rf_wen  output  1  register file write enable (registered)
rf_rd  output  ADDR_W  register file write index (registered)
rf_wdata  output  DATA_W  register file write data (registered)
pending  output  NREG  scoreboard vector; bit i set means register i has a write outstanding
wb_err  output  1  sticky: writeback to a non-pending register, or a reserved index ≥ NREG

Behaviour:
Reset (synchronous):
- rf_wen=0, rf_rd=0, rf_wdata=0, pending=0, wb_err=0.
- Round-robin pointer set to favour A.
- rst overrides every request in the same cycle; any writeback in flight is dropped.

Arbitration (combinational grant, registered output):
- Only A valid -> a_ready=1. Only B valid -> b_ready=1.
- Both valid -> grant the side named by the pointer. After any grant the pointer moves to the other side.
- At most one of a_ready/b_ready is high per cycle.
- A request is transferred when valid&&ready. The requester must hold valid/rd/data stable until ready.

Write commit:
- On the clk edge after a transfer: rf_rd=rd, rf_wdata=data, rf_wen=(rd!=0).
- Latency from transfer to rf_wen is 1 cycle. With no transfer, rf_wen=0 the next cycle.
- rd==0 is accepted and consumed, but never writes and never touches the scoreboard.

Scoreboard:
- Set pending[issue_rd] when issue_valid&&issue_ready&&issue_rd!=0.
- Clear pending[rf_rd] on the cycle rf_wen=1; the bit is 0 from the following cycle.
- Set and clear of the same index in the same cycle -> set wins.
- issue_ready = !(issue_rd!=0 && pending[issue_rd]) — stall on WAW.
- raw_hazard = (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]).
- No bypass: a consumer's hazard drops the cycle after rf_wen, when the register file read returns the new value.

Errors:
- Transfer with rd!=0 and pending[rd]==0 -> wb_err=1 (sticky until rst). The write still proceeds.
- Index ≥ NREG on issue_rd or a writeback rd -> wb_err=1. That index is ignored for the scoreboard.

Test Plan:
- Issue x5 -> pending[5]=1; rs1=5 gives raw_hazard=1. A writes x5=0x1234 -> a_ready; next cycle rf_wen=1, rf_rd=5, rf_wdata=0x1234; the cycle after, pending[5]=0 and raw_hazard=0.
- Issue x3 and x4; A (x3) and B (x4) valid together for 2 cycles -> A granted first, then B. rf_wen pulses on consecutive cycles. Pointer ends favouring A.
- With x7 pending, issue_rd=7 -> issue_ready=0 until the write to x7 commits, then issue_ready=1.
- A writes rd=0 with data 0xFFFFFFFF -> a_ready=1, rf_wen stays 0, pending unchanged, wb_err=0.
- B writes x9 while pending[9]=0 -> wb_err=1 and rf_wen=1 next cycle. wb_err holds until rst.
- Assert rst while a transfer is in flight and several pending bits are set -> next cycle rf_wen=0, pending=0, wb_err=0, and A wins the next simultaneous request.
